// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, almost flags, sticky errors; SYNC_FIFO_FWFT_EN selects first-word-fall-through read
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_THRESH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;
  logic              rd_acc, wr_acc;
  assign full         = count_q == FULL_CNT;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_CNT;
  assign almost_empty = count_q <= AE_CNT;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign rd_acc       = rd_en & ~empty;
  assign wr_acc       = wr_en & (~full | rd_acc);
  // next pointers, occupancy and sticky error flags; clr_err beats a same-cycle set
  always_comb begin
    wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_acc);
    count_d     = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
    overflow_d  = ~clr_err & (overflow_q | (wr_en & ~wr_acc));
    underflow_d = ~clr_err & (underflow_q | (rd_en & empty));
  end
  // control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
  // storage is not reset; a write when full with a pop lands in the slot being freed
  always_ff @(posedge clk) begin
    if (wr_acc & ~rst) mem[wr_ptr_q] <= wr_data;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign rd_data  = mem[rd_ptr_q];
  assign rd_valid = ~empty;
`else
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  // registered read: head word captured on an accepted pop, held otherwise
  always_comb begin
    rd_data_d  = rd_acc ? mem[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
  end
  // read output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (DEPTH=16, DATA_W=8)
module tb_sync_fifo_param;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wr_data = '0, rd_data, d;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int         n_cmp = 0, n_err = 0;
  wire [6:0]  status = {full, empty, almost_full, almost_empty, overflow, underflow, rd_valid};
  always #5 clk = ~clk;
  sync_fifo_param dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );
  function automatic logic [6:0] st(input int cnt, input bit ovf, input bit udf, input bit vld);
`ifdef SYNC_FIFO_FWFT_EN
    return {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, ovf, udf, cnt != 0};
`else
    return {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, ovf, udf, vld};
`endif
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] v);
    wr_en = 1'b1;
    wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic pop(output logic [7:0] v);
    logic [7:0] pre;
    rd_en = 1'b1;
    pre = rd_data;
    tick();
    rd_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    v = pre;
`else
    v = rd_data;
`endif
  endtask
  task automatic test_reset;
    tick();
    tick();
    n_cmp++;
    if ({count, status} !== {5'd0, st(0, 0, 0, 0)}) begin
      n_err++;
      $display("FAIL reset_state: got count=%0d status=%b, want count=0 status=%b", count, status, st(0, 0, 0, 0));
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++;
    if (rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_rd_data: got %h, want 00", rd_data);
    end
`endif
    rst = 1'b0;
  endtask
  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      n_cmp++;
      if ({count, status} !== {5'(i + 1), st(i + 1, 0, 0, 0)}) begin
        n_err++;
        $display("FAIL fill_%0d: got count=%0d status=%b, want count=%0d status=%b", i, count, status, i + 1, st(i + 1, 0, 0, 0));
      end
    end
    push(8'hEE);
    n_cmp++;
    if ({count, status} !== {5'd16, st(16, 1, 0, 0)}) begin
      n_err++;
      $display("FAIL overflow_write: got count=%0d status=%b, want count=16 status=%b", count, status, st(16, 1, 0, 0));
    end
  endtask
  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      pop(d);
      n_cmp++;
      if (d !== 8'(i)) begin
        n_err++;
        $display("FAIL drain_data_%0d: got %h, want %h", i, d, 8'(i));
      end
      n_cmp++;
      if ({count, status} !== {5'(15 - i), st(15 - i, 1, 0, 1)}) begin
        n_err++;
        $display("FAIL drain_status_%0d: got count=%0d status=%b, want count=%0d status=%b", i, count, status, 15 - i, st(15 - i, 1, 0, 1));
      end
    end
    tick();
    n_cmp++;
    if (status !== st(0, 1, 0, 0)) begin
      n_err++;
      $display("FAIL idle_valid: got status=%b, want %b", status, st(0, 1, 0, 0));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_cmp++;
    if ({count, status} !== {5'd0, st(0, 1, 1, 0)}) begin
      n_err++;
      $display("FAIL underflow_read: got count=%0d status=%b, want count=0 status=%b", count, status, st(0, 1, 1, 0));
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++;
    if (rd_data !== 8'h0F) begin
      n_err++;
      $display("FAIL underflow_hold: got %h, want 0f", rd_data);
    end
`endif
    clr_err = 1'b1;
    rd_en = 1'b1;
    tick();
    clr_err = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if (status !== st(0, 0, 0, 0)) begin
      n_err++;
      $display("FAIL clr_err_priority: got status=%b, want %b", status, st(0, 0, 0, 0));
    end
  endtask
  task automatic test_full_rw;
    logic [7:0] pre, e;
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'hAA;
    pre = rd_data;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    d = pre;
`else
    d = rd_data;
`endif
    n_cmp++;
    if (d !== 8'h10) begin
      n_err++;
      $display("FAIL full_rw_data: got %h, want 10", d);
    end
    n_cmp++;
    if ({count, status} !== {5'd16, st(16, 0, 0, 1)}) begin
      n_err++;
      $display("FAIL full_rw_status: got count=%0d status=%b, want count=16 status=%b", count, status, st(16, 0, 0, 1));
    end
    for (int i = 0; i < 16; i++) begin
      e = (i < 15) ? 8'h11 + 8'(i) : 8'hAA;
      pop(d);
      n_cmp++;
      if (d !== e || count !== 5'(15 - i)) begin
        n_err++;
        $display("FAIL full_rw_drain_%0d: got data=%h count=%0d, want data=%h count=%0d", i, d, count, e, 15 - i);
      end
    end
  endtask
  task automatic test_empty_rw;
    logic [7:0] pre, e;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if ({count, status} !== {5'd1, st(1, 0, 1, 0)}) begin
      n_err++;
      $display("FAIL empty_rw: got count=%0d status=%b, want count=1 status=%b", count, status, st(1, 0, 1, 0));
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    for (int i = 0; i < 40; i++) begin
      e = (i == 0) ? 8'h55 : 8'h60 + 8'(i - 1);
      wr_en = 1'b1;
      rd_en = 1'b1;
      wr_data = 8'h60 + 8'(i);
      pre = rd_data;
      tick();
`ifdef SYNC_FIFO_FWFT_EN
      d = pre;
`else
      d = rd_data;
`endif
      n_cmp++;
      if (d !== e || {count, status} !== {5'd1, st(1, 0, 0, 1)}) begin
        n_err++;
        $display("FAIL wrap_%0d: got data=%h count=%0d status=%b, want data=%h count=1 status=%b", i, d, count, status, e, st(1, 0, 0, 1));
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    pop(d);
    n_cmp++;
    if (d !== 8'h87 || count !== 5'd0) begin
      n_err++;
      $display("FAIL wrap_last: got data=%h count=%0d, want data=87 count=0", d, count);
    end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    n_cmp++;
    if (count !== 5'd9) begin
      n_err++;
      $display("FAIL pre_reset_count: got %0d, want 9", count);
    end
    rst = 1'b1;
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 8'hEE;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_cmp++;
    if ({count, status} !== {5'd0, st(0, 0, 0, 0)}) begin
      n_err++;
      $display("FAIL mid_reset: got count=%0d status=%b, want count=0 status=%b", count, status, st(0, 0, 0, 0));
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_cmp++;
    if (rd_data !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_rd_data: got %h, want 00", rd_data);
    end
`endif
    push(8'h33);
    pop(d);
    n_cmp++;
    if (d !== 8'h33 || count !== 5'd0) begin
      n_err++;
      $display("FAIL post_reset_read: got data=%h count=%0d, want data=33 count=0", d, count);
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_full_rw();
    test_empty_rw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
